// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: datapath widths, PC increment and the fetch-queue entry.
package cpu_pkg;
  localparam int XLEN   = 32;
  localparam int INST_W = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fq_entry_t;
endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-to-decode handshake: valid/ready plus the head instruction word, its address and address+4.
interface fetch_unit_if;
  import cpu_pkg::*;
  logic              id_valid;
  logic              id_ready;
  logic [INST_W-1:0] id_inst;
  logic [XLEN-1:0]   id_pc;
  logic [XLEN-1:0]   id_pc_plus4;

  modport master (output id_valid, id_inst, id_pc, id_pc_plus4, input id_ready);
  modport slave  (input id_valid, id_inst, id_pc, id_pc_plus4, output id_ready);
endinterface

// File: rtl/fetch_unit_queue.sv
// Circular FIFO of fetched {pc, inst}; head is registered and reads as zero when empty.
// Flush has priority over push and pop; push and pop together leave the count unchanged.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_flush,
  input  logic                         i_push,
  input  fq_entry_t                    i_push_dat,
  input  logic                         i_pop,
  output fq_entry_t                    o_head,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  fq_entry_t          r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [PTR_W-1:0]   w_wr_nxt;
  logic [PTR_W-1:0]   w_rd_nxt;

  // Explicit wrap so non-power-of-two depths stay in range.
  assign w_wr_nxt = (r_wr_ptr == PTR_W'(DEPTH-1)) ? '0 : r_wr_ptr + PTR_W'(1);
  assign w_rd_nxt = (r_rd_ptr == PTR_W'(DEPTH-1)) ? '0 : r_rd_ptr + PTR_W'(1);

  always_ff @(posedge i_clk) begin
    if (i_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_push_dat;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= w_wr_nxt;
      if (i_pop)  r_rd_ptr <= w_rd_nxt;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
  assign o_count = r_count;
endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC register, instruction-memory request and a decoupling queue toward decode; one-cycle fetch-to-decode latency.
// Stalls when the queue is full and decode is not ready; redirect flushes the queue. Macro FETCH_MISALIGN_TRAP_EN enables the misaligned-redirect trap.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              FQ_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [XLEN-1:0]   imem_pc,
  input  logic [INST_W-1:0] imem_inst,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              fetch_misalign,
  fetch_unit_if.master      id_if
);
  localparam int CNT_W = $clog2(FQ_DEPTH+1);

  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  w_redirect_tgt;
  logic             w_halted;
  logic             w_deq;
  logic             w_fire;
  logic             w_full;
  logic [CNT_W-1:0] w_count;
  fq_entry_t        w_push_dat;
  fq_entry_t        w_head;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic r_halted;
  logic r_misalign;

  // Any redirect re-evaluates alignment, so an aligned target clears the trap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_halted   <= 1'b0;
      r_misalign <= 1'b0;
    end else if (redirect_valid) begin
      r_halted   <= |redirect_pc[1:0];
      r_misalign <= |redirect_pc[1:0];
    end
  end

  assign w_redirect_tgt = redirect_pc;
  assign w_halted       = r_halted;
  assign fetch_misalign = r_misalign;
`else
  assign w_redirect_tgt = redirect_pc & ~32'h3;
  assign w_halted       = 1'b0;
  assign fetch_misalign = 1'b0;
`endif

  assign w_full = (w_count == CNT_W'(FQ_DEPTH));
  assign w_deq  = id_if.id_valid & id_if.id_ready;
  assign w_fire = rst_n & ~redirect_valid & ~w_halted & (~w_full | w_deq);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_pc <= w_redirect_tgt;
    end else if (w_fire) begin
      r_pc <= r_pc + PC_STEP;
    end
  end

  assign imem_pc         = r_pc;
  assign w_push_dat.pc   = r_pc;
  assign w_push_dat.inst = imem_inst;

  fetch_queue #(.DEPTH(FQ_DEPTH)) u_queue (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_flush    (redirect_valid),
    .i_push     (w_fire),
    .i_push_dat (w_push_dat),
    .i_pop      (w_deq & ~redirect_valid),
    .o_head     (w_head),
    .o_count    (w_count)
  );

  assign id_if.id_valid    = (w_count != '0);
  assign id_if.id_inst     = w_head.inst;
  assign id_if.id_pc       = w_head.pc;
  assign id_if.id_pc_plus4 = id_if.id_valid ? w_head.pc + PC_STEP : '0;
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 Parameter FQ_DEPTH, default 2, the fetch-queue entry count; legal range 2..8.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 imem_pc  output  32  byte address presented to instruction memory; equals the internal PC register.
REQ-006 imem_inst  input  32  instruction word returned combinationally for imem_pc in the same cycle.
REQ-007 redirect_valid  input  1  branch/jump/trap redirect request from execute.
REQ-008 redirect_pc  input  32  redirect target byte address.
REQ-009 id_valid  output  1  queue head holds a valid instruction for decode.
REQ-010 id_ready  input  1  decode accepts the head this cycle.
REQ-011 id_inst  output  32  head instruction word.
REQ-012 id_pc  output  32  head instruction address.
REQ-013 id_pc_plus4  output  32  id_pc + 4, modulo 2^32.
REQ-014 fetch_misalign  output  1  sticky misaligned-redirect error flag.

Function
REQ-015 Fetch fire = rst_n & ~redirect_valid & ~halted & (count < FQ_DEPTH | deq); deq = id_valid & id_ready.
REQ-016 On fetch fire, {imem_pc, imem_inst} SHALL be written at the queue tail and PC <= PC + 4, wrapping 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-017 Queue is FIFO, circular head/tail pointers; count SHALL increment on fire-only, decrement on deq-only, stay unchanged on fire+deq.
REQ-018 id_valid = (count != 0); id_inst/id_pc/id_pc_plus4 SHALL come from the registered head entry, no combinational path from imem_inst.
REQ-019 Latency: instruction fetched at edge N is visible on id_* after edge N, i.e. one cycle.
REQ-020 id_* SHALL remain stable while id_valid & ~id_ready.
REQ-021 redirect_valid SHALL have priority over fire and deq: queue emptied (count <= 0), PC <= redirect target, no enqueue, no deq counted that cycle.
REQ-022 After a redirect cycle, id_valid SHALL be 0 for exactly one cycle, then show the target instruction, absent further redirects.
REQ-023 Back-to-back redirects: the last one wins; no instruction from an intermediate target reaches decode.
REQ-024 Full queue with id_ready=0: PC and queue SHALL hold; imem_pc unchanged.

Reset
REQ-025 While rst_n=0 at an edge: PC <= RESET_PC, count/pointers <= 0, halted <= 0, fetch_misalign <= 0.
REQ-026 Outputs after reset: imem_pc=RESET_PC, id_valid=0; id_inst/id_pc/id_pc_plus4 SHALL be 0 while count=0.
REQ-027 Reset mid-stream SHALL discard all queued entries; first post-reset id_valid is the RESET_PC instruction.

Configuration
REQ-028 Macro FETCH_MISALIGN_TRAP_EN defined: redirect_pc[1:0]!=0 SHALL set fetch_misalign and halted, load PC with redirect_pc unchanged, and stop fetching until an aligned redirect clears both.
REQ-029 Macro undefined: redirect_pc[1:0] SHALL be forced to 2'b00, halted never set, fetch_misalign tied 0; port retained.

Structure
REQ-030 Shared package cpu_pkg SHALL hold XLEN=32, INST_W=32, PC_STEP=4, and the fetch-queue entry struct {pc, inst}.
REQ-031 Queue SHALL be a sub-module fetch_queue (parameterised depth, push/pop/flush, count); PC logic stays in fetch_unit.

Verification
REQ-032 Reset release, id_ready=1, RESET_PC=0: id_pc sequence 0x0,0x4,0x8 on consecutive cycles, starting one cycle after release.
REQ-033 id_ready=0 for 5 cycles from reset: count saturates at 2, imem_pc holds 0x8, id_pc holds 0x0; id_ready=1 then delivers 0x0,0x4,0x8 with no gap.
REQ-034 Redirect to 0x100 while queue full: next cycle id_valid=0, following cycle id_pc=0x100, id_pc_plus4=0x104; 0x4 never delivered.
REQ-035 PC preset by redirect to 0xFFFF_FFFC: delivered id_pc 0xFFFF_FFFC then 0x0, id_pc_plus4 of first = 0x0.
REQ-036 With FETCH_MISALIGN_TRAP_EN, redirect to 0x102: fetch_misalign=1, id_valid stays 0; redirect to 0x200 clears flag and delivers 0x200. Without macro: delivers 0x100, flag 0.
REQ-037 rst_n low one cycle with 2 entries queued: id_valid=0 next cycle, then id_pc=RESET_PC.
